// File: rtl/fir_out_serializer.sv
// Rounds and saturates FIR accumulator results to 16 bits, queues them in a small FIFO
// and emits each one as a two-byte frame (high byte first) on a byte-wide stream.
module fir_out_serializer #(
  parameter int ACC_W      = 20,
  parameter int OUT_SHIFT  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ACC_W-1:0]              acc_in,
  input  logic                          acc_valid,
  output logic                          acc_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_first,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [7:0]                    sat_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic signed [ACC_W:0] ROUND_K = (ACC_W+1)'(1 << (OUT_SHIFT-1));
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-32768);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND_HI = 2'd1,
    S_SEND_LO = 2'd2
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_acc_ready;
  logic [7:0]         r_sat_count;
  logic [7:0]         r_tx_data;
  logic [7:0]         r_lo_byte;
  logic               r_tx_first;
  logic               r_tx_valid;
  logic [15:0]        r_mem [FIFO_DEPTH];

  logic signed [ACC_W:0] w_r;
  logic signed [ACC_W:0] w_q;
  logic               w_clip_hi;
  logic               w_clip_lo;
  logic [15:0]        w_sample;
  logic [15:0]        w_rd_data;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level_nxt;

  // Arithmetic shift makes the rounding half toward +inf for negative results too.
  assign w_r       = $signed({acc_in[ACC_W-1], acc_in}) + ROUND_K;
  assign w_q       = w_r >>> OUT_SHIFT;
  assign w_clip_hi = (w_q > SAT_MAX);
  assign w_clip_lo = (w_q < SAT_MIN);
  assign w_sample  = w_clip_hi ? 16'h7FFF : (w_clip_lo ? 16'h8000 : w_q[15:0]);

  // Both streams are valid/ready: a word moves on a rising edge where valid && ready,
  // and the source holds the word stable until that edge.
  assign w_empty     = (r_level == '0);
  assign w_push      = acc_valid && r_acc_ready;
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_SEND_LO) && tx_ready));
  assign w_rd_data   = r_mem[r_rd_ptr];
  assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_acc_ready <= 1'b0;
      r_sat_count <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level     <= w_level_nxt;
      r_acc_ready <= (w_level_nxt != FULL_LVL);
      if (w_push && (w_clip_hi || w_clip_lo) && (r_sat_count != 8'hFF)) begin
        r_sat_count <= r_sat_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_first <= 1'b0;
      r_tx_valid <= 1'b0;
      r_lo_byte  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_lo_byte  <= w_rd_data[7:0];
            r_tx_data  <= w_rd_data[15:8];
            r_tx_first <= 1'b1;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND_HI;
          end
        end
        S_SEND_HI: begin
          if (tx_ready) begin
            r_tx_data  <= r_lo_byte;
            r_tx_first <= 1'b0;
            r_state    <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (tx_ready) begin
            if (!w_empty) begin
              r_lo_byte  <= w_rd_data[7:0];
              r_tx_data  <= w_rd_data[15:8];
              r_tx_first <= 1'b1;
              r_state    <= S_SEND_HI;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign acc_ready  = r_acc_ready;
  assign tx_data    = r_tx_data;
  assign tx_first   = r_tx_first;
  assign tx_valid   = r_tx_valid;
  assign sat_count  = r_sat_count;
  assign fifo_level = r_level;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fir_out_serializer.sv
// Bench for fir_out_serializer: inputs change 2ns after posedge, everything is sampled on negedge.
module tb_fir_out_serializer;

  localparam int ACC_W      = 20;
  localparam int OUT_SHIFT  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ACC_W-1:0] acc_in = '0;
  logic             acc_valid = 1'b0;
  logic             acc_ready;
  logic [7:0]       tx_data;
  logic             tx_first;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic [7:0]       sat_count;
  logic [LVL_W-1:0] fifo_level;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;
  int exp_sat  = 0;
  logic [15:0] exp_q[$];

  bit          have_hi = 0;
  logic [7:0]  hi_byte;
  bit          hold_seen = 0;
  logic [7:0]  hold_data;
  logic        hold_first;
  bit          mon_clip;
  logic [15:0] mon_exp;

  fir_out_serializer #(
    .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .tx_data(tx_data), .tx_first(tx_first), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sat_count(sat_count), .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] model(input logic [ACC_W-1:0] a, output bit clip);
    int v;
    int q;
    v = int'($signed(a));
    q = (v + (1 << (OUT_SHIFT-1))) >>> OUT_SHIFT;
    clip = 0;
    if (q > 32767) begin clip = 1; return 16'h7FFF; end
    if (q < -32768) begin clip = 1; return 16'h8000; end
    return q[15:0];
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_sat   = 0;
      have_hi   = 0;
      hold_seen = 0;
    end else begin
      if (hold_seen) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== hold_data || tx_first !== hold_first) begin
          failures++;
          $display("FAIL hold_stable: got v=%b d=%h f=%b, required v=1 d=%h f=%b",
                   tx_valid, tx_data, tx_first, hold_data, hold_first);
        end
      end
      hold_seen  = tx_valid && !tx_ready;
      hold_data  = tx_data;
      hold_first = tx_first;
      if (acc_valid && acc_ready) begin
        mon_exp = model(acc_in, mon_clip);
        exp_q.push_back(mon_exp);
        if (mon_clip && exp_sat < 255) exp_sat++;
      end
      if (tx_valid && tx_ready) begin
        checks++;
        if (tx_first) begin
          if (have_hi) begin
            failures++;
            $display("FAIL frame_order: got second hi byte %h, required a lo byte", tx_data);
          end
          have_hi = 1;
          hi_byte = tx_data;
        end else begin
          if (!have_hi || exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected: got lo %h (hi pending=%0d queued=%0d), required hi first and a queued sample",
                     tx_data, have_hi, exp_q.size());
          end else begin
            mon_exp = exp_q.pop_front();
            if ({hi_byte, tx_data} !== mon_exp) begin
              failures++;
              $display("FAIL frame_data: got %h, required %h", {hi_byte, tx_data}, mon_exp);
            end
          end
          have_hi = 0;
          frames++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_acc(input logic [ACC_W-1:0] v);
    int n;
    acc_in = v;
    acc_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (acc_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (acc_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_acc_timeout: acc_ready=%b after %0d cycles, required 1", acc_ready, n);
    end
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic capture_frame(output logic [15:0] f, output int nbytes);
    nbytes = 0;
    f = '0;
    for (int i = 0; i < 20 && nbytes < 2; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        f = {f[7:0], tx_data};
        nbytes++;
      end
    end
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || tx_valid || fifo_level != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || tx_valid !== 1'b0 || fifo_level !== '0) begin
      failures++;
      $display("FAIL drain_timeout: queued=%0d tx_valid=%b level=%0d, required 0/0/0",
               exp_q.size(), tx_valid, fifo_level);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; acc_valid = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0)  begin failures++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    checks++; if (tx_first !== 1'b0)  begin failures++; $display("FAIL reset_tx_first: got %b, required 0", tx_first); end
    checks++; if (tx_data !== 8'h00)  begin failures++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    checks++; if (sat_count !== 8'h00) begin failures++; $display("FAIL reset_sat_count: got %h, required 00", sat_count); end
    checks++; if (fifo_level !== '0)  begin failures++; $display("FAIL reset_fifo_level: got %0d, required 0", fifo_level); end
    checks++; if (acc_ready !== 1'b0) begin failures++; $display("FAIL reset_acc_ready: got %b, required 0", acc_ready); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL post_reset_acc_ready: got %b, required 1", acc_ready); end
    tick();
  endtask

  task automatic test_basic();
    int nvalid;
    logic [7:0] bd [2];
    logic       bf [2];
    tx_ready = 1'b1;
    send_acc(20'h00123);
    nvalid = 0;
    bd[0] = 8'hxx; bd[1] = 8'hxx; bf[0] = 1'bx; bf[1] = 1'bx;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        if (nvalid < 2) begin bd[nvalid] = tx_data; bf[nvalid] = tx_first; end
        nvalid++;
      end
    end
    checks++; if (nvalid != 2)     begin failures++; $display("FAIL basic_valid_cycles: got %0d, required 2", nvalid); end
    checks++; if (bd[0] !== 8'h00 || bf[0] !== 1'b1) begin failures++; $display("FAIL basic_hi: got %h/%b, required 00/1", bd[0], bf[0]); end
    checks++; if (bd[1] !== 8'h12 || bf[1] !== 1'b0) begin failures++; $display("FAIL basic_lo: got %h/%b, required 12/0", bd[1], bf[1]); end
    checks++; if (sat_count !== 8'h00) begin failures++; $display("FAIL basic_sat: got %0d, required 0", sat_count); end
    tick();
    wait_drain();
  endtask

  task automatic test_rounding();
    logic [ACC_W-1:0] vin [3];
    logic [15:0]      vexp [3];
    logic [15:0]      f;
    int               nb;
    vin[0] = 20'hFFFE8; vexp[0] = 16'hFFFF;
    vin[1] = 20'hFFFE7; vexp[1] = 16'hFFFE;
    vin[2] = 20'h00008; vexp[2] = 16'h0001;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_acc(vin[i]);
      capture_frame(f, nb);
      checks++;
      if (nb != 2 || f !== vexp[i]) begin
        failures++;
        $display("FAIL rounding_%0d: got %h (%0d bytes), required %h", i, f, nb, vexp[i]);
      end
      wait_drain();
    end
    checks++; if (sat_count !== 8'h00) begin failures++; $display("FAIL rounding_sat: got %0d, required 0", sat_count); end
  endtask

  task automatic test_saturation();
    logic [15:0] f;
    int          nb;
    tx_ready = 1'b1;
    send_acc(20'h7FFFF);
    capture_frame(f, nb);
    checks++; if (nb != 2 || f !== 16'h7FFF) begin failures++; $display("FAIL sat_pos_frame: got %h, required 7fff", f); end
    wait_drain();
    checks++; if (sat_count !== 8'd1) begin failures++; $display("FAIL sat_pos_count: got %0d, required 1", sat_count); end
    send_acc(20'h80000);
    capture_frame(f, nb);
    checks++; if (nb != 2 || f !== 16'h8000) begin failures++; $display("FAIL sat_neg_frame: got %h, required 8000", f); end
    wait_drain();
    checks++; if (sat_count !== 8'd1) begin failures++; $display("FAIL sat_neg_count: got %0d, required 1", sat_count); end
    // Any input at or above 0x7FFF8 rounds past 32767.
    for (int i = 0; i < 300; i++) begin
      send_acc(ACC_W'($urandom_range(32'h7FFFF, 32'h7FFF8)));
    end
    wait_drain();
    checks++; if (sat_count !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d, required 255", sat_count); end
  endtask

  task automatic test_backpressure();
    int idx;
    int accepted;
    int f0;
    bit took;
    f0 = frames;
    tx_ready = 1'b0;
    idx = 1;
    acc_in = ACC_W'(idx << 4);
    acc_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      took = acc_valid && acc_ready;
      if (took) accepted++;
      tick();
      if (took) begin
        idx++;
        if (idx > 6) acc_valid = 1'b0; else acc_in = ACC_W'(idx << 4);
      end
    end
    @(negedge clk);
    // One sample sits in the output register and FIFO_DEPTH more in the FIFO.
    checks++; if (accepted != FIFO_DEPTH + 1) begin failures++; $display("FAIL bp_accepted: got %0d, required %0d", accepted, FIFO_DEPTH + 1); end
    checks++; if (acc_ready !== 1'b0) begin failures++; $display("FAIL bp_acc_ready: got %b, required 0", acc_ready); end
    checks++; if (fifo_level !== LVL_W'(FIFO_DEPTH)) begin failures++; $display("FAIL bp_level: got %0d, required %0d", fifo_level, FIFO_DEPTH); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00 || tx_first !== 1'b1) begin
      failures++; $display("FAIL bp_hold_out: got v=%b d=%h f=%b, required 1/00/1", tx_valid, tx_data, tx_first);
    end
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL bp_state: got %0d, required 1", dbg_state); end
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 60 && acc_valid; i++) begin
      @(negedge clk);
      took = acc_valid && acc_ready;
      tick();
      if (took) begin
        idx++;
        if (idx > 6) acc_valid = 1'b0; else acc_in = ACC_W'(idx << 4);
      end
    end
    checks++; if (acc_valid !== 1'b0) begin failures++; $display("FAIL bp_release_timeout: got idx=%0d, required 7", idx); end
    acc_valid = 1'b0;
    wait_drain();
    checks++; if (frames - f0 != 6) begin failures++; $display("FAIL bp_frames: got %0d, required 6", frames - f0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vbits;
    logic [7:0] fbits;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_acc(ACC_W'($urandom_range(32'h3FFFF, 0)));
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vbits[i] = tx_valid;
      fbits[i] = tx_first & tx_valid;
    end
    checks++; if (vbits !== 8'b0011_1111) begin failures++; $display("FAIL b2b_valid: got %b, required 00111111", vbits); end
    checks++; if (fbits !== 8'b0001_0101) begin failures++; $display("FAIL b2b_first: got %b, required 00010101", fbits); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL b2b_idle: got %0d, required 0", dbg_state); end
    tick();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int          nvalid;
    logic [15:0] f;
    int          nb;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_acc(ACC_W'((i + 9) << 4));
    tx_ready = 1'b1;
    @(negedge clk);
    tick();
    tx_ready = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL rm_pre_state: got %0d, required 2", dbg_state); end
    checks++; if (fifo_level !== LVL_W'(2)) begin failures++; $display("FAIL rm_pre_level: got %0d, required 2", fifo_level); end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0)  begin failures++; $display("FAIL rm_tx_valid: got %b, required 0", tx_valid); end
    checks++; if (fifo_level !== '0)  begin failures++; $display("FAIL rm_level: got %0d, required 0", fifo_level); end
    checks++; if (sat_count !== 8'h00) begin failures++; $display("FAIL rm_sat: got %0d, required 0", sat_count); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rm_state: got %0d, required 0", dbg_state); end
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin failures++; $display("FAIL rm_stale: got %0d valid cycles, required 0", nvalid); end
    tick();
    send_acc(20'h00A5F);
    capture_frame(f, nb);
    checks++; if (nb != 2 || f !== 16'h00A6) begin failures++; $display("FAIL rm_after: got %h, required 00a6", f); end
    wait_drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required test sequence to finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
